// File: rtl/seg_pkg.sv
// Shared constants for 7-segment display blocks: glyph table and segment bus layout.
package seg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_DP = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = '0;

  // Index 15 first; entry n is the g..a pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment (g..a, active-high) decoder.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = SEG_HEX[hex];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with shadowed digit/dp/blink registers, leading-zero
// blanking, blink and 16-level PWM brightness. seg/ena are registered, one clk behind idx.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_FRAMES   = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          ENA_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  input  logic [3:0]            bright,
  output logic [SEG_W-1:0]      seg,
  output logic [DIGITS-1:0]     ena,
  output logic                  frame_tick
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned TW = DW + 5;

  localparam logic [SEG_W-1:0]  SEG_IDLE = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] ENA_IDLE = {DIGITS{ENA_ACTIVE_LOW}};

  logic [DW-1:0]         div_cnt_q;
  logic [IW-1:0]         idx_q;
  logic [BW-1:0]         blink_cnt_q;
  logic                  phase_q;
  logic [4*DIGITS-1:0]   pend_dig_q, act_dig_q;
  logic [DIGITS-1:0]     pend_dp_q, act_dp_q, pend_blink_q, act_blink_q;
  logic                  pend_valid_q;
  // Stays low after reset until the first shadow transfer, keeping the display dark.
  logic                  act_valid_q;
  logic [SEG_W-1:0]      seg_q;
  logic [DIGITS-1:0]     ena_q;
  logic                  frame_q;

  logic                  slot_end, frame_end;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic [DIGITS-1:0]     lz_mask;
  logic                  seen_nz;
  logic [TW-1:0]         pwm_thr;
  logic                  lit;
  logic [SEG_W-1:0]      seg_d;
  logic [DIGITS-1:0]     ena_d;

  assign slot_end  = en && (div_cnt_q == DW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
  assign nibble    = act_dig_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex  (nibble),
    .seg7 (glyph)
  );

  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (act_dig_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      lz_mask[i] = lz_blank && !seen_nz && (i != 0);
    end
  end

  always_comb begin
    pwm_thr = ((TW'(bright) + TW'(1)) * TW'(SCAN_DIV)) >> 4;
    lit     = en && act_valid_q && !lz_mask[idx_q] && !(act_blink_q[idx_q] && phase_q)
              && (TW'(div_cnt_q) < pwm_thr);
    seg_d   = SEG_OFF;
    ena_d   = '0;
    if (lit) begin
      seg_d = {act_dp_q[idx_q], glyph};
      ena_d = DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      act_valid_q  <= 1'b0;
      seg_q        <= SEG_IDLE;
      ena_q        <= ENA_IDLE;
      frame_q      <= 1'b0;
    end else begin
      if (en) begin
        if (slot_end) begin
          div_cnt_q <= '0;
          idx_q     <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
          div_cnt_q <= div_cnt_q + DW'(1);
        end
      end
      frame_q <= frame_end;
      if (frame_end) begin
        if (pend_valid_q) begin
          act_dig_q   <= pend_dig_q;
          act_dp_q    <= pend_dp_q;
          act_blink_q <= pend_blink_q;
          act_valid_q <= 1'b1;
        end
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
      // A load coinciding with the boundary lands in pending and waits one more frame.
      if (load) begin
        pend_dig_q   <= digits_in;
        pend_dp_q    <= dp_in;
        pend_blink_q <= blink_mask;
        pend_valid_q <= 1'b1;
      end else if (frame_end) begin
        pend_valid_q <= 1'b0;
      end
      seg_q <= seg_d ^ SEG_IDLE;
      ena_q <= ena_d ^ ENA_IDLE;
    end
  end

  assign seg        = seg_q;
  assign ena        = ena_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench: fast-scan instance (SCAN_DIV=4, BLINK_FRAMES=2) and a PWM instance (SCAN_DIV=16).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic [3:0]  bright;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  ena_a, ena_b;
  logic        ft_a, ft_b;

  int total = 0;
  int bad   = 0;

  logic [3:0] cap_ena [16];
  logic [7:0] cap_seg [16];
  logic       cap_ft  [16];

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0), .ENA_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .bright(bright),
    .seg(seg_a), .ena(ena_a), .frame_tick(ft_a)
  );

  seg_scan_ctrl #(
    .DIGITS(4), .SCAN_DIV(16), .BLINK_FRAMES(250), .SEG_ACTIVE_LOW(1'b0), .ENA_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .bright(bright),
    .seg(seg_b), .ena(ena_b), .frame_tick(ft_b)
  );

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
      4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
      4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
      4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input bit sel);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if ((sel ? ft_b : ft_a) === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wait_tick dut%0d: frame_tick stayed 0 for 200 clks, required a pulse", sel);
    end
  endtask

  // Records one dut_a frame starting at a frame_tick sample; optional load at step load_at.
  task automatic capture_frame(input int load_at, input logic [15:0] word);
    for (int k = 0; k < 16; k++) begin
      if (k == load_at) begin
        digits_in = word;
        load      = 1'b1;
      end
      step();
      load       = 1'b0;
      cap_ena[k] = ena_a;
      cap_seg[k] = seg_a;
      cap_ft[k]  = ft_a;
    end
  endtask

  task automatic load_and_apply(input logic [15:0] word);
    wait_tick(1'b0);
    digits_in = word;
    load      = 1'b1;
    step();
    load = 1'b0;
    wait_tick(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; blink_mask = '0;
    lz_blank = 1'b0; bright = 4'd15;
    #1 rst_n = 1'b0;
    #1;
    total += 5;
    if (ena_a !== 4'b0)  begin bad++; $display("FAIL reset ena_a: got %b want 0000", ena_a); end
    if (seg_a !== 8'h00) begin bad++; $display("FAIL reset seg_a: got %h want 00", seg_a); end
    if (ft_a !== 1'b0)   begin bad++; $display("FAIL reset ft_a: got %b want 0", ft_a); end
    if (ena_b !== 4'b0)  begin bad++; $display("FAIL reset ena_b: got %b want 0000", ena_b); end
    if (seg_b !== 8'h00) begin bad++; $display("FAIL reset seg_b: got %h want 00", seg_b); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] w = 16'h1234;
    logic [3:0]  e_ena;
    logic [7:0]  e_seg;
    en = 1'b1; bright = 4'd15; digits_in = w; load = 1'b1;
    step();
    load = 1'b0;
    wait_tick(1'b0);
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      e_ena = 4'(1 << (k / 4));
      e_seg = hex7(w[4*(k/4) +: 4]);
      total += 3;
      if (cap_ena[k] !== e_ena) begin
        bad++; $display("FAIL basic ena k=%0d: got %b want %b", k, cap_ena[k], e_ena);
      end
      if (cap_seg[k] !== e_seg) begin
        bad++; $display("FAIL basic seg k=%0d: got %h want %h", k, cap_seg[k], e_seg);
      end
      if (cap_ft[k] !== (k == 15)) begin
        bad++; $display("FAIL basic frame_tick k=%0d: got %b want %b", k, cap_ft[k], k == 15);
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] e_ena1 [4] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
    logic [7:0] e_seg1 [4] = '{8'h3F, 8'h07, 8'h00, 8'h00};
    logic [3:0] e_ena2 [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [7:0] e_seg2 [4] = '{8'h3F, 8'h00, 8'h00, 8'h00};
    lz_blank = 1'b1;
    dp_in    = 4'b1100;
    load_and_apply(16'h0070);
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      total += 2;
      if (cap_ena[k] !== e_ena1[k/4]) begin
        bad++; $display("FAIL lz0070 ena k=%0d: got %b want %b", k, cap_ena[k], e_ena1[k/4]);
      end
      if (cap_seg[k] !== e_seg1[k/4]) begin
        bad++; $display("FAIL lz0070 seg k=%0d: got %h want %h", k, cap_seg[k], e_seg1[k/4]);
      end
    end
    dp_in = 4'b0000;
    load_and_apply(16'h0000);
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      total += 2;
      if (cap_ena[k] !== e_ena2[k/4]) begin
        bad++; $display("FAIL lz0000 ena k=%0d: got %b want %b", k, cap_ena[k], e_ena2[k/4]);
      end
      if (cap_seg[k] !== e_seg2[k/4]) begin
        bad++; $display("FAIL lz0000 seg k=%0d: got %h want %h", k, cap_seg[k], e_seg2[k/4]);
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_pwm();
    logic [3:0] br  [3] = '{4'd7, 4'd0, 4'd15};
    int         thr [3] = '{8, 1, 16};
    logic [3:0] e_ena;
    logic [7:0] e_seg;
    load_and_apply(16'h0000);
    wait_tick(1'b1);
    wait_tick(1'b1);
    for (int t = 0; t < 3; t++) begin
      bright = br[t];
      wait_tick(1'b1);
      for (int k = 0; k < 16; k++) begin
        step();
        e_ena = (k < thr[t]) ? 4'b0001 : 4'b0000;
        e_seg = (k < thr[t]) ? 8'h3F : 8'h00;
        total += 2;
        if (ena_b !== e_ena) begin
          bad++; $display("FAIL pwm b=%0d ena k=%0d: got %b want %b", br[t], k, ena_b, e_ena);
        end
        if (seg_b !== e_seg) begin
          bad++; $display("FAIL pwm b=%0d seg k=%0d: got %h want %h", br[t], k, seg_b, e_seg);
        end
        if (br[t] == 4'd0) begin
          total++;
          if (ena_a !== 4'b0000) begin
            bad++; $display("FAIL pwm_zero_thr ena_a k=%0d: got %b want 0000", k, ena_a);
          end
        end
      end
    end
    bright = 4'd15;
  endtask

  task automatic test_blink();
    bit         lit;
    logic [3:0] e_ena;
    logic [7:0] e_seg;
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1; en = 1'b1; bright = 4'd15; lz_blank = 1'b0;
    digits_in = 16'h1234; dp_in = 4'b0001; blink_mask = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    wait_tick(1'b0);
    for (int f = 1; f <= 4; f++) begin
      capture_frame(-1, 16'h0);
      lit   = (f == 1) || (f == 4);
      e_ena = lit ? 4'b0001 : 4'b0000;
      e_seg = lit ? 8'hE6 : 8'h00;
      total += 5;
      if (cap_ena[0] !== e_ena) begin
        bad++; $display("FAIL blink f=%0d d0 ena: got %b want %b", f, cap_ena[0], e_ena);
      end
      if (cap_seg[0] !== e_seg) begin
        bad++; $display("FAIL blink f=%0d d0 seg: got %h want %h", f, cap_seg[0], e_seg);
      end
      if (cap_ena[4] !== 4'b0010) begin
        bad++; $display("FAIL blink f=%0d d1 ena: got %b want 0010", f, cap_ena[4]);
      end
      if (cap_seg[4] !== 8'h4F) begin
        bad++; $display("FAIL blink f=%0d d1 seg: got %h want 4F", f, cap_seg[4]);
      end
      if (cap_ft[15] !== 1'b1) begin
        bad++; $display("FAIL blink f=%0d frame_tick: got %b want 1", f, cap_ft[15]);
      end
    end
    dp_in = 4'b0000; blink_mask = 4'b0000;
  endtask

  task automatic test_load_shadow();
    int          la   [6] = '{6, -1, 0, 15, -1, -1};
    logic [15:0] lw   [6] = '{16'hABCD, 16'h0, 16'h5678, 16'h0F0F, 16'h0, 16'h0};
    logic [15:0] show [6] = '{16'h1234, 16'hABCD, 16'hABCD, 16'h5678, 16'h5678, 16'h0F0F};
    logic [15:0] w;
    logic [7:0]  e_seg;
    logic [3:0]  e_ena;
    load_and_apply(16'h1234);
    for (int f = 0; f < 6; f++) begin
      capture_frame(la[f], lw[f]);
      w = show[f];
      for (int k = 0; k < 16; k++) begin
        e_ena = 4'(1 << (k / 4));
        e_seg = hex7(w[4*(k/4) +: 4]);
        total += 2;
        if (cap_ena[k] !== e_ena) begin
          bad++; $display("FAIL shadow f=%0d ena k=%0d: got %b want %b", f, k, cap_ena[k], e_ena);
        end
        if (cap_seg[k] !== e_seg) begin
          bad++; $display("FAIL shadow f=%0d seg k=%0d: got %h want %h", f, k, cap_seg[k], e_seg);
        end
      end
    end
  endtask

  task automatic test_reset_pause();
    step();
    step();
    rst_n = 1'b0;
    #1;
    total += 4;
    if (ena_a !== 4'b0)  begin bad++; $display("FAIL async_rst ena_a: got %b want 0000", ena_a); end
    if (seg_a !== 8'h00) begin bad++; $display("FAIL async_rst seg_a: got %h want 00", seg_a); end
    if (ft_a !== 1'b0)   begin bad++; $display("FAIL async_rst ft_a: got %b want 0", ft_a); end
    if (ena_b !== 4'b0)  begin bad++; $display("FAIL async_rst ena_b: got %b want 0000", ena_b); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total += 2;
      if (ena_a !== 4'b0)  begin bad++; $display("FAIL post_rst ena k=%0d: got %b want 0000", k, ena_a); end
      if (seg_a !== 8'h00) begin bad++; $display("FAIL post_rst seg k=%0d: got %h want 00", k, seg_a); end
    end
    load_and_apply(16'h1234);
    repeat (5) step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total += 3;
      if (ena_a !== 4'b0)  begin bad++; $display("FAIL pause ena k=%0d: got %b want 0000", k, ena_a); end
      if (seg_a !== 8'h00) begin bad++; $display("FAIL pause seg k=%0d: got %h want 00", k, seg_a); end
      if (ft_a !== 1'b0)   begin bad++; $display("FAIL pause ft k=%0d: got %b want 0", k, ft_a); end
    end
    en = 1'b1;
    step();
    total += 2;
    if (ena_a !== 4'b0010) begin bad++; $display("FAIL resume ena: got %b want 0010", ena_a); end
    if (seg_a !== 8'h4F)   begin bad++; $display("FAIL resume seg: got %h want 4F", seg_a); end
    for (int i = 2; i <= 11; i++) begin
      step();
      total++;
      if (ft_a !== (i == 11)) begin
        bad++; $display("FAIL resume frame_tick i=%0d: got %b want %b", i, ft_a, i == 11);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_pwm();
    test_blink();
    test_load_shadow();
    test_reset_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
